// File: rtl/tf520_cpu_bridge_if.sv
// 68EC020 side, Amiga 68000/6800 side and grant signals of the TF520 bridge.
interface tf520_cpu_bridge_if;
  logic       AS20;
  logic       DS20_1;
  logic       DS20_2;
  logic       RW20;
  logic [2:0] FC;
  logic [1:0] SIZ;
  logic       A0;
  logic [3:0] A;
  logic       BG20;
  logic       BGACK;
  logic       DTACK;
  logic       VPA;
  logic       HIGH;
  logic       AS;
  logic       UDS;
  logic       LDS;
  logic       RW00;
  logic       VMA;
  logic       E;
  logic       DSACK1;
  logic       AVEC;
  logic       BG;

  modport slave (
    input  AS20, DS20_1, DS20_2, RW20, FC, SIZ, A0, A, BG20, BGACK, DTACK, VPA, HIGH,
    output AS, UDS, LDS, RW00, VMA, E, DSACK1, AVEC, BG
  );

  modport master (
    output AS20, DS20_1, DS20_2, RW20, FC, SIZ, A0, A, BG20, BGACK, DTACK, VPA, HIGH,
    input  AS, UDS, LDS, RW00, VMA, E, DSACK1, AVEC, BG
  );
endinterface

// File: rtl/tf520_cpu_bridge.sv
// Runs 68EC020 cycles as 68000/6800 cycles paced by a sampled CLK7M; all outputs but BG registered.
// Cycle length follows DTACK/VPA (no timeout); the 020 is held off by withholding DSACK1.
module tf520_cpu_bridge #(
  parameter int E_DIV  = 10,
  parameter int E_HIGH = 4
) (
  input logic               CLK20M,
  input logic               RESET,
  input logic               CLK7M,
  tf520_cpu_bridge_if.slave bus
);
  localparam int            CW       = $clog2(E_DIV);
  localparam logic [CW-1:0] E_LAST   = CW'(E_DIV - 1);
  localparam logic [CW-1:0] E_ON     = CW'(E_DIV - E_HIGH);
  localparam logic [CW-1:0] VMA_SLOT = CW'(3);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT7, S_WSTB, S_ACK, S_VPAW, S_VWAIT, S_DONE, S_TERM
  } state_t;

  state_t        state, state_nxt;
  logic          clk7_s1, clk7_s2, clk7_d;
  logic          dtack_s1, dtack_s, vpa_s1, vpa_s, bgack_s1, bgack_s;
  logic          r7, f7;
  logic [CW-1:0] ecnt, ecnt_nxt;
  logic          e_q, avec_q;
  logic          as_q, uds_q, lds_q, rw_q, vma_q, dsack_q, rw_l, uds_en, lds_en;
  logic          as_nxt, uds_nxt, lds_nxt, rw_nxt, vma_nxt, dsack_nxt;
  logic          rw_l_nxt, uds_en_nxt, lds_en_nxt;
  logic          cpu_space, ds_act;

  always_ff @(posedge CLK20M or posedge RESET) begin
    if (RESET) begin
      {clk7_s1, clk7_s2, clk7_d} <= 3'b000;
      {dtack_s1, dtack_s, vpa_s1, vpa_s, bgack_s1, bgack_s} <= 6'b111111;
    end else begin
      {clk7_d, clk7_s2, clk7_s1} <= {clk7_s2, clk7_s1, CLK7M};
      {dtack_s, dtack_s1} <= {dtack_s1, bus.DTACK};
      {vpa_s, vpa_s1}     <= {vpa_s1, bus.VPA};
      {bgack_s, bgack_s1} <= {bgack_s1, bus.BGACK};
    end
  end

  assign r7 = clk7_s2 & ~clk7_d;
  assign f7 = ~clk7_s2 & clk7_d;

  // E free-runs off CLK7M falling edges regardless of bus activity.
  assign ecnt_nxt = (ecnt == E_LAST) ? '0 : ecnt + CW'(1);

  always_ff @(posedge CLK20M or posedge RESET) begin
    if (RESET) begin
      ecnt <= '0;
      e_q  <= 1'b0;
    end else if (f7) begin
      ecnt <= ecnt_nxt;
      e_q  <= (ecnt_nxt >= E_ON);
    end
  end

  assign cpu_space = (bus.FC == 3'b111) && (bus.A == 4'hF);
  assign ds_act    = ~bus.DS20_1 & ~bus.DS20_2;

  always_ff @(posedge CLK20M or posedge RESET) begin
    if (RESET)                        avec_q <= 1'b1;
    else if (!bus.AS20 && cpu_space)  avec_q <= 1'b0;
    else if (bus.AS20)                avec_q <= 1'b1;
  end

  always_ff @(posedge CLK20M or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      as_q    <= 1'b1;
      uds_q   <= 1'b1;
      lds_q   <= 1'b1;
      rw_q    <= 1'b1;
      vma_q   <= 1'b1;
      dsack_q <= 1'b1;
      rw_l    <= 1'b1;
      uds_en  <= 1'b0;
      lds_en  <= 1'b0;
    end else begin
      state   <= state_nxt;
      as_q    <= as_nxt;
      uds_q   <= uds_nxt;
      lds_q   <= lds_nxt;
      rw_q    <= rw_nxt;
      vma_q   <= vma_nxt;
      dsack_q <= dsack_nxt;
      rw_l    <= rw_l_nxt;
      uds_en  <= uds_en_nxt;
      lds_en  <= lds_en_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    as_nxt     = as_q;
    uds_nxt    = uds_q;
    lds_nxt    = lds_q;
    rw_nxt     = rw_q;
    vma_nxt    = vma_q;
    dsack_nxt  = dsack_q;
    rw_l_nxt   = rw_l;
    uds_en_nxt = uds_en;
    lds_en_nxt = lds_en;
    // An 020 abort is only acted on at a 7M falling edge so strobes end on a bus phase.
    if ((state inside {S_WAIT7, S_WSTB, S_ACK, S_VPAW, S_VWAIT}) && bus.AS20) begin
      if (f7) begin
        {as_nxt, uds_nxt, lds_nxt, vma_nxt, rw_nxt} = 5'b11111;
        state_nxt = S_IDLE;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.AS20 && bus.HIGH && bgack_s && !cpu_space) begin
            rw_l_nxt   = bus.RW20;
            uds_en_nxt = ~bus.A0;
            lds_en_nxt = bus.A0 | (bus.SIZ != 2'b01);
            state_nxt  = S_WAIT7;
          end
        end
        S_WAIT7: begin
          if (f7) begin
            as_nxt = 1'b0;
            rw_nxt = rw_l;
            if (rw_l) begin
              uds_nxt   = ~uds_en;
              lds_nxt   = ~lds_en;
              state_nxt = S_ACK;
            end else begin
              state_nxt = S_WSTB;
            end
          end
        end
        S_WSTB: begin
          // Write strobes wait half a 7M period and for the 020 data strobe.
          if (r7 && ds_act) begin
            uds_nxt   = ~uds_en;
            lds_nxt   = ~lds_en;
            state_nxt = S_ACK;
          end
        end
        S_ACK: begin
          if (f7) begin
            if (!dtack_s)    state_nxt = S_DONE;
            else if (!vpa_s) state_nxt = S_VPAW;
          end
        end
        S_VPAW: begin
          if (ecnt == VMA_SLOT) begin
            vma_nxt   = 1'b0;
            state_nxt = S_VWAIT;
          end
        end
        S_VWAIT: begin
          if (f7 && ecnt == E_LAST) state_nxt = S_DONE;
        end
        S_DONE: begin
          dsack_nxt = bus.AS20;
          if (f7) begin
            {as_nxt, uds_nxt, lds_nxt, vma_nxt, rw_nxt} = 5'b11111;
            state_nxt = bus.AS20 ? S_IDLE : S_TERM;
          end
        end
        S_TERM: begin
          if (bus.AS20) begin
            dsack_nxt = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus.AS     = as_q;
  assign bus.UDS    = uds_q;
  assign bus.LDS    = lds_q;
  assign bus.RW00   = rw_q;
  assign bus.VMA    = vma_q;
  assign bus.E      = e_q;
  assign bus.DSACK1 = dsack_q;
  assign bus.AVEC   = avec_q;
  assign bus.BG     = bus.BG20;
endmodule

// File: tb/tb_tf520_cpu_bridge.sv
// Directed bench for tf520_cpu_bridge with a per-cycle reference model for E, AVEC and BG.
module tb_tf520_cpu_bridge;
  logic CLK20M = 1'b0;
  logic CLK7M  = 1'b0;
  logic RESET  = 1'b1;

  tf520_cpu_bridge_if bus();

  tf520_cpu_bridge #(.E_DIV(10), .E_HIGH(4)) dut (
    .CLK20M(CLK20M),
    .RESET (RESET),
    .CLK7M (CLK7M),
    .bus   (bus)
  );

  // 50 and 140 time-unit periods: CLK7M edges never coincide with CLK20M rising edges.
  always #25 CLK20M = ~CLK20M;
  always #70 CLK7M  = ~CLK7M;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: the bridge sees CLK7M through a synchronizer; E is high for the last 4 of every 10 falls.
  logic [2:0] hist;
  int         ecnt_m;
  logic       e_m, avec_m, as20_edge;

  always @(posedge CLK20M or posedge RESET) begin
    if (RESET) begin
      hist      <= 3'b000;
      ecnt_m    <= 0;
      e_m       <= 1'b0;
      avec_m    <= 1'b1;
      as20_edge <= 1'b1;
    end else begin
      if (hist[2] && !hist[1]) begin
        ecnt_m <= (ecnt_m + 1) % 10;
        e_m    <= (((ecnt_m + 1) % 10) >= 6);
      end
      if (!bus.AS20 && bus.FC == 3'b111 && bus.A == 4'hF) avec_m <= 1'b0;
      else if (bus.AS20)                                  avec_m <= 1'b1;
      as20_edge <= bus.AS20;
      hist      <= {hist[1:0], CLK7M};
    end
  end

  always @(negedge CLK20M) begin
    if (chk_on && !RESET) begin
      check("bg_pass", bus.BG, bus.BG20);
      check("e_model", bus.E, e_m);
      check("avec_model", bus.AVEC, avec_m);
      if (bus.DSACK1 == 1'b0) check("dsack_needs_as20", as20_edge, 1'b0);
      if (bus.AS == 1'b1) check("strobes_need_as", {bus.UDS, bus.LDS, bus.VMA}, 3'b111);
    end
  end

  function automatic logic sig(input int s);
    case (s)
      0:       return bus.AS;
      1:       return bus.DSACK1;
      2:       return bus.VMA;
      3:       return bus.UDS;
      4:       return bus.LDS;
      5:       return bus.E;
      default: return bus.AVEC;
    endcase
  endfunction

  task automatic drv();
    @(negedge CLK20M);
    #5;
  endtask

  task automatic wait_for(input int s, input logic v, input int max, input string nm, output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK20M);
      cyc++;
    end while (sig(s) !== v && cyc < max);
    if (sig(s) !== v) check(nm, sig(s), v);
  endtask

  task automatic start_cycle(input logic rw, input logic [1:0] siz, input logic a0,
                             input logic [2:0] fc, input logic [3:0] a);
    drv();
    bus.RW20 = rw; bus.SIZ = siz; bus.A0 = a0; bus.FC = fc; bus.A = a;
    bus.AS20 = 1'b0; bus.DS20_1 = 1'b0; bus.DS20_2 = 1'b0;
  endtask

  task automatic end_cycle();
    drv();
    bus.AS20 = 1'b1; bus.DS20_1 = 1'b1; bus.DS20_2 = 1'b1;
    bus.DTACK = 1'b1; bus.VPA = 1'b1; bus.RW20 = 1'b1;
  endtask

  task automatic bus_cycle(input string nm, input logic rw, input logic [1:0] siz, input logic a0,
                           input logic exp_u, input logic exp_l);
    int c;
    int lat;
    start_cycle(rw, siz, a0, 3'b101, 4'h2);
    wait_for(0, 1'b0, 12, {nm, " as_timeout"}, c);
    check({nm, " rw00"}, bus.RW00, rw);
    if (!rw) begin
      check({nm, " wr_strobes_late"}, {bus.UDS, bus.LDS}, 2'b11);
      wait_for(exp_u ? 4 : 3, 1'b0, 4, {nm, " wr_strobe_timeout"}, c);
      check({nm, " wr_strobe_delay"}, (c >= 1 && c <= 2), 1'b1);
    end
    check({nm, " uds"}, bus.UDS, exp_u);
    check({nm, " lds"}, bus.LDS, exp_l);
    repeat (2) @(posedge CLK7M);
    bus.DTACK = 1'b0;
    wait_for(1, 1'b0, 12, {nm, " dsack_timeout"}, lat);
    check({nm, " dsack_latency"}, (lat >= 3 && lat <= 9), 1'b1);
    repeat (4) @(negedge CLK20M);
    check({nm, " dsack_hold"}, bus.DSACK1, 1'b0);
    end_cycle();
    @(negedge CLK20M);
    check({nm, " dsack_release"}, bus.DSACK1, 1'b1);
    wait_for(0, 1'b1, 6, {nm, " as_release"}, c);
    check({nm, " strobes_released"}, {bus.UDS, bus.LDS, bus.RW00}, 3'b111);
    repeat (3) @(negedge CLK20M);
  endtask

  task automatic vpa_cycle();
    int c;
    bit saw_vma = 1'b0;
    bit e_hi    = 1'b0;
    bit as_up   = 1'b0;
    bit done    = 1'b0;
    start_cycle(1'b1, 2'b01, 1'b1, 3'b101, 4'hF);
    wait_for(0, 1'b0, 12, "vpa as_timeout", c);
    check("vpa strobes", {bus.UDS, bus.LDS}, 2'b10);
    bus.VPA = 1'b0;
    c = 0;
    while (!done && c < 120) begin
      @(negedge CLK20M);
      c++;
      if (bus.AS) as_up = 1'b1;
      if (!saw_vma && !bus.VMA) begin
        saw_vma = 1'b1;
        check("vpa vma_in_e_low", bus.E, 1'b0);
      end
      if (saw_vma && bus.E) e_hi = 1'b1;
      if (!bus.DSACK1) done = 1'b1;
    end
    check("vpa dsack_seen", done, 1'b1);
    check("vpa vma_before_dsack", saw_vma, 1'b1);
    check("vpa e_high_before_dsack", e_hi, 1'b1);
    check("vpa dsack_in_e_low", bus.E, 1'b0);
    check("vpa as_held", as_up, 1'b0);
    end_cycle();
    @(negedge CLK20M);
    check("vpa dsack_release", bus.DSACK1, 1'b1);
    wait_for(2, 1'b1, 6, "vpa vma_release", c);
    repeat (3) @(negedge CLK20M);
  endtask

  task automatic no_start(input string nm);
    bit bad = 1'b0;
    repeat (3) @(negedge CLK20M);
    start_cycle(1'b1, 2'b10, 1'b0, 3'b101, 4'h2);
    repeat (30) begin
      @(negedge CLK20M);
      if (!bus.AS) bad = 1'b1;
    end
    check(nm, bad, 1'b0);
    end_cycle();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int h;
    int l;
    bit bad;
    bus.AS20 = 1'b1; bus.DS20_1 = 1'b1; bus.DS20_2 = 1'b1; bus.RW20 = 1'b1;
    bus.FC = 3'b101; bus.SIZ = 2'b00; bus.A0 = 1'b0; bus.A = 4'h2;
    bus.BG20 = 1'b1; bus.BGACK = 1'b1; bus.DTACK = 1'b1; bus.VPA = 1'b1; bus.HIGH = 1'b1;
    repeat (3) @(negedge CLK20M);
    check("reset strobes", {bus.AS, bus.UDS, bus.LDS, bus.RW00, bus.VMA}, 5'b11111);
    check("reset acks", {bus.DSACK1, bus.AVEC, bus.E}, 3'b110);
    #5 RESET = 1'b0;
    chk_on = 1'b1;

    // E: 28 CLK20M cycles per 10 CLK7M periods, high for 4 of them (11.2 cycles).
    wait_for(5, 1'b1, 40, "e_rise_timeout", c);
    h = 0;
    while (bus.E && h < 40) begin @(negedge CLK20M); h++; end
    l = 0;
    while (!bus.E && l < 40) begin @(negedge CLK20M); l++; end
    check("e_high_len", (h >= 11 && h <= 12), 1'b1);
    check("e_period", h + l, 28);

    for (int i = 0; i < 4; i++) begin
      drv();
      bus.BG20 = i[0];
      @(negedge CLK20M);
      check("bg_literal", bus.BG, i[0]);
    end

    bus_cycle("rd_byte0", 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    bus_cycle("rd_byte1", 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    bus_cycle("rd_word0", 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    bus_cycle("rd_long0", 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    vpa_cycle();

    // CPU-space acknowledge: autovector only, no 68000 cycle.
    start_cycle(1'b1, 2'b01, 1'b1, 3'b111, 4'hF);
    @(negedge CLK20M);
    check("avec_assert", bus.AVEC, 1'b0);
    bad = 1'b0;
    repeat (20) begin
      @(negedge CLK20M);
      if (!bus.AS) bad = 1'b1;
    end
    check("cpu_space_no_as", bad, 1'b0);
    check("cpu_space_no_dsack", bus.DSACK1, 1'b1);
    end_cycle();
    @(negedge CLK20M);
    check("avec_release", bus.AVEC, 1'b1);
    drv();
    bus.FC = 3'b101; bus.A = 4'h2;

    bus_cycle("wr_word0", 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
    bus_cycle("wr_byte1", 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a 68000 cycle.
    start_cycle(1'b1, 2'b10, 1'b0, 3'b101, 4'h2);
    wait_for(0, 1'b0, 12, "rst as_timeout", c);
    #3 RESET = 1'b1;
    #2;
    check("rst strobes", {bus.AS, bus.UDS, bus.LDS, bus.RW00, bus.VMA}, 5'b11111);
    check("rst dsack", bus.DSACK1, 1'b1);
    check("rst e", bus.E, 1'b0);
    bus.AS20 = 1'b1; bus.DS20_1 = 1'b1; bus.DS20_2 = 1'b1;
    repeat (2) @(negedge CLK20M);
    #5 RESET = 1'b0;
    repeat (3) @(negedge CLK20M);

    drv();
    bus.BGACK = 1'b0;
    no_start("bgack_blocks_as");
    drv();
    bus.BGACK = 1'b1;
    bus.HIGH  = 1'b0;
    no_start("high_strap_blocks_as");
    drv();
    bus.HIGH = 1'b1;
    repeat (3) @(negedge CLK20M);

    bus_cycle("rd_3byte_after_rst", 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
